vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_if.sv | 40 ++++
 rtl/vga_timing.sv | 94 +++++++++
 tb/tb_vga_timing.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Video timing bundle: sync, visible-pixel address and the one-clock-early fetch request.
// The timing generator drives it (master); the pixel pipeline consumes it (slave).
interface vga_timing_if;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic       fetch;
    logic [9:0] fetch_x;
    logic [9:0] fetch_y;
    logic       frame_start;
    logic       line_start;

    modport master (
        output hsync,
        output vsync,
        output active,
        output x,
        output y,
        output fetch,
        output fetch_x,
        output fetch_y,
        output frame_start,
        output line_start
    );

    modport slave (
        input hsync,
        input vsync,
        input active,
        input x,
        input y,
        input fetch,
        input fetch_x,
        input fetch_y,
        input frame_start,
        input line_start
    );
endinterface

// File: rtl/vga_timing.sv
// Parameterised VGA raster timing generator with registered outputs and a
// pixel fetch request that runs one clock ahead of the visible-pixel strobe.
module vga_timing #(
    parameter int H_ACTIVE         = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_ACTIVE         = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int SYNC_ACTIVE_HIGH = 0
) (
    input  logic         clock,
    input  logic         reset,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Region boundaries are precomputed at elaboration in full integer width,
    // so nothing can overflow the 10-bit counters for totals up to 1023.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
    localparam logic SYNC_OFF = (SYNC_ACTIVE_HIGH == 0);

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       v_wrap;
    logic       vis_now;
    logic       vis_next;
    logic       hs_on;
    logic       vs_on;

    // Next raster position plus region decode of both the current and next position.
    always_comb begin
        h_wrap   = (h == H_LAST);
        v_wrap   = (v == V_LAST);
        h_next   = h_wrap ? 10'd0 : h + 10'd1;
        v_next   = v;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : v + 10'd1;
        end
        vis_now  = (h < H_VIS_END) && (v < V_VIS_END);
        vis_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
        hs_on    = (h >= HS_BEGIN) && (h < HS_END);
        vs_on    = (v >= VS_BEGIN) && (v < VS_END);
    end

    // During reset the fetch port already presents position (0,0) so the pixel
    // pipeline has its first word ready on the first post-release edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            h               <= 10'd0;
            v               <= 10'd0;
            vga.hsync       <= SYNC_OFF;
            vga.vsync       <= SYNC_OFF;
            vga.active      <= 1'b0;
            vga.x           <= 10'd0;
            vga.y           <= 10'd0;
            vga.fetch       <= 1'b1;
            vga.fetch_x     <= 10'd0;
            vga.fetch_y     <= 10'd0;
            vga.frame_start <= 1'b0;
            vga.line_start  <= 1'b0;
        end else begin
            h               <= h_next;
            v               <= v_next;
            vga.hsync       <= hs_on ? SYNC_ON : SYNC_OFF;
            vga.vsync       <= vs_on ? SYNC_ON : SYNC_OFF;
            vga.active      <= vis_now;
            vga.x           <= vis_now ? h : 10'd0;
            vga.y           <= vis_now ? v : 10'd0;
            vga.frame_start <= vis_now && (h == 10'd0) && (v == 10'd0);
            vga.line_start  <= vis_now && (h == 10'd0);
            vga.fetch       <= vis_next;
            vga.fetch_x     <= vis_next ? h_next : 10'd0;
            vga.fetch_y     <= vis_next ? v_next : 10'd0;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two small-raster instances (both sync polarities) checked every
// clock against a time-based model, plus a default 640x480 instance checked at key points.
module tb_vga_timing;

    localparam int SHA = 8;
    localparam int SHF = 2;
    localparam int SHS = 3;
    localparam int SHB = 2;
    localparam int SVA = 5;
    localparam int SVF = 1;
    localparam int SVS = 2;
    localparam int SVB = 1;
    localparam int SHT = SHA + SHF + SHS + SHB;
    localparam int SVT = SVA + SVF + SVS + SVB;
    localparam int SFRAME = SHT * SVT;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        logic       fetch;
        logic [9:0] fetch_x;
        logic [9:0] fetch_y;
        logic       frame_start;
        logic       line_start;
    } outs_t;

    typedef struct {
        int    t;
        outs_t e;
    } def_vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    outs_t    exp_q[$];
    def_vec_t vec_q[$];
    int       fs_times[$];

    int t_rel     = 0;
    int cur_t     = 0;
    bit cur_reset = 1'b1;

    int active_cnt[2];
    int vs_cnt[2];
    int hs_low_cnt = 0;
    int hs_first   = -1;

    always #5 clock = ~clock;

    vga_timing_if bus_lo ();
    vga_timing_if bus_hi ();
    vga_timing_if bus_def ();

    vga_timing #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_lo (
        .clock(clock),
        .reset(reset),
        .vga(bus_lo)
    );

    vga_timing #(
        .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE_HIGH(1)
    ) dut_hi (
        .clock(clock),
        .reset(reset),
        .vga(bus_hi)
    );

    vga_timing dut_def (
        .clock(clock),
        .reset(reset),
        .vga(bus_def)
    );

    function automatic outs_t mk(int hs, int vs, int act, int x, int y,
                                 int f, int fx, int fy, int fs, int ls);
        outs_t o;
        o.hsync       = (hs != 0);
        o.vsync       = (vs != 0);
        o.active      = (act != 0);
        o.x           = 10'(x);
        o.y           = 10'(y);
        o.fetch       = (f != 0);
        o.fetch_x     = 10'(fx);
        o.fetch_y     = 10'(fy);
        o.frame_start = (fs != 0);
        o.line_start  = (ls != 0);
        return o;
    endfunction

    function automatic outs_t pack_outs(logic hs, logic vs, logic act, logic [9:0] x, logic [9:0] y,
                                        logic f, logic [9:0] fx, logic [9:0] fy, logic fs, logic ls);
        outs_t o;
        o = {hs, vs, act, x, y, f, fx, fy, fs, ls};
        return o;
    endfunction

    // Expected small-raster outputs after an edge, derived from clocks elapsed since reset release.
    function automatic outs_t model(bit in_reset, int t, bit pol_high);
        int pos, hh, vv, npos, nh, nv;
        int vis, nvis, hs_on, vs_on, idle, hs, vs;
        idle = pol_high ? 0 : 1;
        if (in_reset) begin
            return mk(idle, idle, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        pos   = t % SFRAME;
        hh    = pos % SHT;
        vv    = pos / SHT;
        npos  = (pos + 1) % SFRAME;
        nh    = npos % SHT;
        nv    = npos / SHT;
        vis   = (hh < SHA && vv < SVA) ? 1 : 0;
        nvis  = (nh < SHA && nv < SVA) ? 1 : 0;
        hs_on = (hh >= SHA + SHF && hh < SHA + SHF + SHS) ? 1 : 0;
        vs_on = (vv >= SVA + SVF && vv < SVA + SVF + SVS) ? 1 : 0;
        hs    = pol_high ? hs_on : 1 - hs_on;
        vs    = pol_high ? vs_on : 1 - vs_on;
        return mk(hs, vs, vis, vis != 0 ? hh : 0, vis != 0 ? vv : 0,
                  nvis, nvis != 0 ? nh : 0, nvis != 0 ? nv : 0,
                  (pos == 0) ? 1 : 0, (vis != 0 && hh == 0) ? 1 : 0);
    endfunction

    task automatic check_outs(string name, outs_t act, outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s t=%0d reset=%0d actual=%h expected=%h", name, cur_t, cur_reset, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add_vec(int t, outs_t e);
        def_vec_t d;
        d.t = t;
        d.e = e;
        vec_q.push_back(d);
    endtask

    // Drive reset for the coming edge, queue both polarities' expectations, advance past the edge.
    task automatic applyStimulus(bit r);
        reset = r;
        exp_q.push_back(model(r, t_rel, 1'b0));
        exp_q.push_back(model(r, t_rel, 1'b1));
        cur_t     = t_rel;
        cur_reset = r;
        t_rel     = r ? 0 : t_rel + 1;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput();
        outs_t e;
        if (exp_q.size() < 2) begin
            check_int("scoreboard_depth", exp_q.size(), 2);
            return;
        end
        e = exp_q.pop_front();
        check_outs("small_lo", pack_outs(bus_lo.hsync, bus_lo.vsync, bus_lo.active, bus_lo.x, bus_lo.y,
                   bus_lo.fetch, bus_lo.fetch_x, bus_lo.fetch_y, bus_lo.frame_start, bus_lo.line_start), e);
        e = exp_q.pop_front();
        check_outs("small_hi", pack_outs(bus_hi.hsync, bus_hi.vsync, bus_hi.active, bus_hi.x, bus_hi.y,
                   bus_hi.fetch, bus_hi.fetch_x, bus_hi.fetch_y, bus_hi.frame_start, bus_hi.line_start), e);
    endtask

    function automatic outs_t def_actual();
        return pack_outs(bus_def.hsync, bus_def.vsync, bus_def.active, bus_def.x, bus_def.y,
                         bus_def.fetch, bus_def.fetch_x, bus_def.fetch_y,
                         bus_def.frame_start, bus_def.line_start);
    endfunction

    initial begin
        int vi;
        int guard;

        // Default 640x480 instance: (hs, vs, active, x, y, fetch, fetch_x, fetch_y, frame_start, line_start)
        add_vec(0,    mk(1, 1, 1, 0,   0, 1, 1,   0, 1, 1));
        add_vec(1,    mk(1, 1, 1, 1,   0, 1, 2,   0, 0, 0));
        add_vec(638,  mk(1, 1, 1, 638, 0, 1, 639, 0, 0, 0));
        add_vec(639,  mk(1, 1, 1, 639, 0, 0, 0,   0, 0, 0));
        add_vec(640,  mk(1, 1, 0, 0,   0, 0, 0,   0, 0, 0));
        add_vec(655,  mk(1, 1, 0, 0,   0, 0, 0,   0, 0, 0));
        add_vec(656,  mk(0, 1, 0, 0,   0, 0, 0,   0, 0, 0));
        add_vec(751,  mk(0, 1, 0, 0,   0, 0, 0,   0, 0, 0));
        add_vec(752,  mk(1, 1, 0, 0,   0, 0, 0,   0, 0, 0));
        add_vec(799,  mk(1, 1, 0, 0,   0, 1, 0,   1, 0, 0));
        add_vec(800,  mk(1, 1, 1, 0,   1, 1, 1,   1, 0, 1));
        add_vec(1455, mk(1, 1, 0, 0,   0, 0, 0,   0, 0, 0));
        add_vec(1456, mk(0, 1, 0, 0,   0, 0, 0,   0, 0, 0));

        active_cnt[0] = 0;
        active_cnt[1] = 0;
        vs_cnt[0]     = 0;
        vs_cnt[1]     = 0;

        $display("[TB] reset phase");
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            checkOutput();
            check_outs("def_reset", def_actual(), mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        end

        $display("[TB] free-run phase");
        vi = 0;
        for (int k = 0; k <= 1456; k++) begin
            applyStimulus(1'b0);
            checkOutput();
            if (cur_t < 2 * SFRAME) begin
                active_cnt[cur_t / SFRAME] += (bus_lo.active === 1'b1) ? 1 : 0;
                vs_cnt[cur_t / SFRAME]     += (bus_lo.vsync === 1'b0) ? 1 : 0;
            end
            if (bus_lo.frame_start === 1'b1) fs_times.push_back(cur_t);
            if (cur_t < 800 && bus_def.hsync === 1'b0) begin
                hs_low_cnt++;
                if (hs_first < 0) hs_first = cur_t;
            end
            if (vi < vec_q.size() && vec_q[vi].t == cur_t) begin
                check_outs($sformatf("def_vec_t%0d", cur_t), def_actual(), vec_q[vi].e);
                vi++;
            end
        end
        check_int("def_vectors_reached", vi, vec_q.size());
        check_int("def_hsync_low_clocks", hs_low_cnt, 96);
        check_int("def_hsync_first_low", hs_first, 656);
        for (int f = 0; f < 2; f++) begin
            check_int($sformatf("small_active_frame%0d", f), active_cnt[f], SHA * SVA);
            check_int($sformatf("small_vsync_frame%0d", f), vs_cnt[f], SVS * SHT);
        end
        if (fs_times.size() >= 3) begin
            check_int("frame_start_first", fs_times[0], 0);
            check_int("frame_start_period0", fs_times[1] - fs_times[0], SFRAME);
            check_int("frame_start_period1", fs_times[2] - fs_times[1], SFRAME);
        end else begin
            check_int("frame_start_count", fs_times.size(), 3);
        end

        // Reset lands while the small raster sits mid hsync pulse (h=11, v=3).
        $display("[TB] mid-frame reset phase");
        guard = 0;
        while ((t_rel % SFRAME) != (3 * SHT + 11) && guard < SFRAME) begin
            applyStimulus(1'b0);
            checkOutput();
            guard++;
        end
        check_int("mid_reset_position_found", ((t_rel % SFRAME) == (3 * SHT + 11)) ? 1 : 0, 1);
        check_int("hsync_before_reset", int'(bus_lo.hsync), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1);
            checkOutput();
            check_outs("def_mid_reset", def_actual(), mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        applyStimulus(1'b0);
        checkOutput();
        check_outs("def_first_after_release", def_actual(), mk(1, 1, 1, 0, 0, 1, 1, 0, 1, 1));
        for (int k = 0; k < SFRAME + 5; k++) begin
            applyStimulus(1'b0);
            checkOutput();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
